// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES definitions: block type, FSM states, round count, RCON and S-box.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_t;

    // Round constants for rounds 1..10, entry 0 belongs to round 1
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for a 1-based round counter; zero outside 1..10
    function automatic logic [7:0] rcon_sel(input logic [3:0] ctr);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (ctr == 4'(i + 1)) r = RCON[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Block-in / ciphertext-out handshake bundle for the iterative AES-128 encryptor.
interface aes128_enc_iter_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t pt_i;
    aes_block_t key_i;
    logic       out_valid;
    logic       out_ready;
    aes_block_t ct_o;
    logic       busy_o;

    modport slave (
        input  in_valid, pt_i, key_i, out_ready,
        output in_ready, out_valid, ct_o, busy_o
    );

    modport master (
        output in_valid, pt_i, key_i, out_ready,
        input  in_ready, out_valid, ct_o, busy_o
    );
endinterface

// File: rtl/aes128_enc_iter_round.sv
// Combinational AES-128 encryption round pieces and the on-the-fly key step.
// Byte i of a block lives at bits [127-8*i -: 8], column-major.

module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] rk_o
);
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = rk_i;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
    assign w_t   = w_sub ^ {rcon_i, 24'h000000};
    assign w_n0  = w_w0 ^ w_t;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign rk_o  = {w_n0, w_n1, w_n2, w_n3};
endmodule

module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign d_o[127-8*i -: 8] = sbox(d_i[127-8*i -: 8]);
    end
endmodule

module shift_rows (
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    // Row r of column c takes row r of column (c+r) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign d_o[127-8*(4*c+r) -: 8] = d_i[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end
endmodule

module mix_cols_enc
    import aes_pkg::*;
(
    input  logic [127:0] d_i,
    input  logic         mix_col_en,
    output logic [127:0] d_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0]  w_a0, w_a1, w_a2, w_a3;
        logic [31:0] w_mix;
        assign {w_a0, w_a1, w_a2, w_a3} = d_i[127-32*c -: 32];
        assign w_mix = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
        assign d_o[127-32*c -: 32] = mix_col_en ? w_mix : d_i[127-32*c -: 32];
    end
endmodule

module add_round_key (
    input  logic [127:0] d_i,
    input  logic [127:0] rk_i,
    output logic [127:0] d_o
);
    assign d_o = d_i ^ rk_i;
endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the fly.
// Optional macro AES_ENC_LAST_KEY_OUT_EN adds last_key_o (final round key, for
// seeding a decryption path).
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic             clk,
    input  logic             rst_n,
    aes128_enc_iter_if.slave bus
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0]     last_key_o
`endif
);

    if (NR != NR_AES128) begin : g_nr_check
        $error("aes128_enc_iter: NR must be 10");
    end

    aes_state_t r_fsm;
    logic [3:0] r_round_ctr;
    aes_block_t r_state;
    aes_block_t r_rk;
    aes_block_t r_ct;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    aes_block_t r_last_key;
`endif

    aes_block_t w_rk_next;
    aes_block_t w_sb, w_sr, w_mc, w_round;
    logic [7:0] w_rcon;
    logic       w_last;

    assign w_rcon = rcon_sel(r_round_ctr);
    assign w_last = (r_round_ctr == 4'(NR));

    aes_key_step u_key_step (
        .rk_i   (r_rk),
        .rcon_i (w_rcon),
        .rk_o   (w_rk_next)
    );

    sub_bytes u_sub_bytes (
        .d_i (r_state),
        .d_o (w_sb)
    );

    shift_rows u_shift_rows (
        .d_i (w_sb),
        .d_o (w_sr)
    );

    mix_cols_enc u_mix_cols (
        .d_i        (w_sr),
        .mix_col_en (!w_last),
        .d_o        (w_mc)
    );

    add_round_key u_add_rk (
        .d_i  (w_mc),
        .rk_i (w_rk_next),
        .d_o  (w_round)
    );

    // Control FSM and datapath registers; all handshake outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_round_ctr <= '0;
            r_state     <= '0;
            r_rk        <= '0;
            r_ct        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            r_last_key  <= '0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state     <= bus.pt_i ^ bus.key_i;
                        r_rk        <= bus.key_i;
                        r_round_ctr <= 4'd1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_fsm       <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_round;
                    r_rk    <= w_rk_next;
                    if (w_last) begin
                        r_ct        <= w_round;
`ifdef AES_ENC_LAST_KEY_OUT_EN
                        r_last_key  <= w_rk_next;
`endif
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_round_ctr <= r_round_ctr + 4'd1;
                    end
                end
                DONE: begin
                    // in_ready rises after the handshake edge, so accept never overlaps it
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_round_ctr <= '0;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ct_o      = r_ct;
    assign bus.busy_o    = r_busy;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign last_key_o    = r_last_key;
`endif

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: known-answer table, handshake corner
// sequences and random blocks against a key-schedule-first AES reference model.
module tb_aes128_enc_iter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    aes128_enc_iter_if bus ();

`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key_o;
`endif

    aes128_enc_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        ,
        .last_key_o (last_key_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from the multiplicative inverse plus the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic void ref_aes(input logic [127:0] key, input logic [127:0] pt,
                                    output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [7:0]  st [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ key[127-8*b -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sb[st[4*(((b/4)+(b%4))%4) + (b%4)]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int b = 0; b < 16; b++) st[b] = t[b];
            end
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = st[b];
        lk = {w[40], w[41], w[42], w[43]};
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction tasks ----------------
    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        chk_b("in_ready_before_send", bus.in_ready, 1'b1);
        bus.key_i    = key;
        bus.pt_i     = pt;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_b("busy_after_accept", bus.busy_o, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        lat = n;
    endtask

    task automatic drain(input int hold, input logic [127:0] exp_ct);
        logic bad;
        bad = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.ct_o !== exp_ct || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.busy_o !== 1'b1) bad = 1'b1;
        end
        chk_b("hold_stable_violation", bad, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk_b("in_ready_during_handshake", bus.in_ready, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        chk_b("in_ready_after_handshake", bus.in_ready, 1'b1);
        chk_b("out_valid_after_handshake", bus.out_valid, 1'b0);
        chk_b("busy_after_handshake", bus.busy_o, 1'b0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] lk;   // zero means not tabulated
    } vec_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        vec_t         vecs [3];
        logic [127:0] mct, mlk, k, p, ct_prev;
        int           lat;

        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pt_i      = '0;
        bus.key_i     = '0;
        rst_n         = 1'b0;

        vecs[0] = '{KEY_B, PT_B, CT_B, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{KEY_C, PT_C, CT_C, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        build_sbox();

        repeat (3) tick();
        chk_b("reset_in_ready", bus.in_ready, 1'b1);
        chk_b("reset_out_valid", bus.out_valid, 1'b0);
        chk_b("reset_busy", bus.busy_o, 1'b0);
        chk("reset_ct", bus.ct_o, 128'h0);
        rst_n = 1'b1;
        tick();

        // Known-answer table
        for (int v = 0; v < 3; v++) begin
            ref_aes(vecs[v].key, vecs[v].pt, mct, mlk);
            chk("model_vs_table_ct", mct, vecs[v].ct);
            send(vecs[v].key, vecs[v].pt);
            wait_out(lat);
            chk_i("latency", lat, 10);
            chk("table_ct", bus.ct_o, vecs[v].ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
            chk("table_last_key", last_key_o, mlk);
            if (vecs[v].lk != 128'h0) chk("table_last_key_const", last_key_o, vecs[v].lk);
`endif
            drain(v, vecs[v].ct);
            tick();
        end

        // Backpressure: ciphertext held for 20 cycles
        send(KEY_B, PT_B);
        wait_out(lat);
        chk("bp_ct", bus.ct_o, CT_B);
        drain(20, CT_B);

        // Busy-input: in_valid/out_ready activity during RUN is ignored
        send(KEY_B, PT_B);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = i[0];
            bus.out_ready = ~i[0];
            bus.pt_i      = {$urandom, $urandom, $urandom, $urandom};
            bus.key_i     = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk_b("busy_in_ready_low", bus.in_ready, 1'b0);
        wait_out(lat);
        chk_i("busy_latency", lat, 4);
        chk("busy_ct", bus.ct_o, CT_B);
        drain(1, CT_B);

        // Reset mid-RUN at round counter 5, ct_o currently holds the App. B result
        ct_prev = bus.ct_o;
        chk("ct_retained_in_idle", ct_prev, CT_B);
        send(KEY_C, PT_C);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk_b("midrst_in_ready", bus.in_ready, 1'b1);
        chk_b("midrst_out_valid", bus.out_valid, 1'b0);
        chk_b("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_ct", bus.ct_o, 128'h0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
        chk("midrst_last_key", last_key_o, 128'h0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        send(KEY_C, PT_C);
        wait_out(lat);
        chk_i("post_reset_latency", lat, 10);
        chk("post_reset_ct", bus.ct_o, CT_C);
        drain(0, CT_C);

        // Back-to-back with out_ready tied high
        begin
            int           cyc, nacc, nout;
            int           acc_cyc [2];
            logic [127:0] got [2];
            logic         acc, hs;
            cyc = 0; nacc = 0; nout = 0;
            acc_cyc[0] = 0; acc_cyc[1] = 0;
            got[0] = '0; got[1] = '0;
            bus.out_ready = 1'b1;
            bus.key_i     = KEY_B;
            bus.pt_i      = PT_B;
            bus.in_valid  = 1'b1;
            while ((nacc < 2 || nout < 2) && cyc < 60) begin
                acc = bus.in_valid & bus.in_ready;
                hs  = bus.out_valid & bus.out_ready;
                if (hs && nout < 2) begin got[nout] = bus.ct_o; nout++; end
                tick();
                cyc++;
                if (acc) begin
                    if (nacc < 2) acc_cyc[nacc] = cyc;
                    nacc++;
                    if (nacc == 1) begin
                        bus.key_i = KEY_C;
                        bus.pt_i  = PT_C;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            chk_i("b2b_accepts", nacc, 2);
            chk_i("b2b_outputs", nout, 2);
            chk_i("b2b_spacing", acc_cyc[1] - acc_cyc[0], 12);
            chk("b2b_ct0", got[0], CT_B);
            chk("b2b_ct1", got[1], CT_C);
            tick();
        end

        // Random blocks against the reference model
        for (int n = 0; n < 16; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            ref_aes(k, p, mct, mlk);
            repeat ($urandom_range(0, 3)) tick();
            send(k, p);
            wait_out(lat);
            chk_i("rand_latency", lat, 10);
            chk("rand_ct", bus.ct_o, mct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
            chk("rand_last_key", last_key_o, mlk);
`endif
            drain(int'($urandom_range(0, 4)), mct);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_enc_iter.md
Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption core: one full round per clock, with on-the-fly round-key expansion.
- Forward-direction counterpart of the decryption round datapath. Its round uses sub_bytes -> shift_rows -> mix_cols_enc -> add_round_key.
- Sits between the block-input staging logic and the ciphertext sink.
- Uses valid/ready handshakes on both sides and processes one 128-bit block at a time.

Parameters:
- NR, 10, number of rounds. Only 10 is legal; any other value triggers an elaboration-time $error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key pair is valid
- in_ready  output  1  core can accept a pair (high only in IDLE)
- pt_i  input  128  plaintext; byte 0 = bits [127:120], column-major per FIPS-197
- key_i  input  128  cipher key, same byte order
- out_valid  output  1  ct_o holds a completed ciphertext
- out_ready  input  1  sink accepts ct_o
- ct_o  output  128  ciphertext
- busy_o  output  1  high in RUN and DONE

Behaviour:
- Reset: asynchronous, active-low. Clears FSM to IDLE, round_ctr=0, state_q=0, rk_q=0, ct_o=0. Outputs: in_ready=1, out_valid=0, busy_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_q <= pt_i^key_i (initial AddRoundKey); rk_q <= key_i; round_ctr <= 1; go to RUN.
- RUN, each cycle:
  - rk_next = key step of rk_q using rcon[round_ctr]. rcon = 01,02,04,08,10,20,40,80,1b,36.
  - state_q <= round(state_q, rk_next), with MixColumns enabled iff round_ctr != NR.
  - rk_q <= rk_next.
  - If round_ctr==NR: load ct_o with the round result and go to DONE. Otherwise round_ctr++.
- DONE:
  - out_valid=1; ct_o held stable until out_valid&out_ready.
  - On that handshake: go to IDLE, round_ctr <= 0.
  - in_ready is not asserted in the same cycle as the handshake (no overlap); the next block is accepted one cycle later.
- Latency: out_valid rises on the 10th rising edge after the accepting edge. Throughput is one block per 12 cycles with out_ready held high.
- in_valid while not in IDLE: ignored; pt_i/key_i are sampled only on accept.
- out_ready while not in DONE: ignored.
- rst_n low mid-RUN or mid-DONE: the block in flight is discarded and the core returns to the IDLE reset state immediately. No partial ciphertext is ever presented.
- All XOR/S-box logic is purely combinational between the registers; there are no arithmetic carries.
- round_ctr is 4 bits and never exceeds NR.

Optional Feature:
- Macro: AES_ENC_LAST_KEY_OUT_EN.
- Defined:
  - Adds output port last_key_o [127:0].
  - last_key_o is loaded with rk_next in the same cycle ct_o is loaded, and is held through DONE.
  - It is the round-10 key the decryption path needs as its starting key.
  - Reset value 0.
- Undefined: the port and its register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg holds:
  - the 10-entry RCON constant array;
  - the NR_AES128 = 10 constant;
  - the FSM state enum typedef (IDLE/RUN/DONE);
  - a 128-bit block typedef.
- Sub-module aes_key_step (combinational): inputs rk_i[127:0], rcon_i[7:0]; output rk_o[127:0].
  - Implements RotWord, SubWord and the rcon XOR, then the word-chain XORs.
- Round logic instantiates the existing sub_bytes, shift_rows, mix_cols_enc (with mix_col_en) and add_round_key blocks.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct_o 3925841d02dc09fbdc118597196a0b32, out_valid on the 10th edge after accept. With the macro, last_key_o = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct_o 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ct_o stable, out_valid=1, in_ready=0 throughout. Pulse out_ready -> in_ready=1 on the following cycle.
- Busy-input: toggle in_valid with different pt_i during RUN -> ignored; ct_o still matches the originally accepted App. B vectors.
- Reset mid-operation: drop rst_n at round_ctr=5 -> outputs go immediately to reset values (in_ready=1, out_valid=0, ct_o=0). A fresh App. C.1 encryption afterwards produces the correct ct_o.
- Back-to-back: App. B then App. C.1 with out_ready tied high -> two correct ciphertexts, accepts 12 cycles apart.
